// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registers one decoded op into the ALU, waits for it to settle, then captures and corrects the result for valid/ready handoff
module alu_issue_stage #(
   parameter int SETTLE_CYCLES = 1,
   parameter bit TRAP_OVF = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [31:0] in_rs,
   input  logic [31:0] in_rt,
   input  logic [15:0] in_imm,
   input  logic        in_use_imm,
   input  logic        in_imm_zext,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [5:0]  alu_func,
   input  logic [31:0] alu_o,
   input  logic        alu_sgn,
   input  logic        alu_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_taken,
   output logic        out_ovf,
   output logic        out_carry,
   output logic        out_illegal
);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [4:0] cur_op;
   logic [5:0] func_n;
   logic [31:0] ext, b_n, bp, res_n;
   logic accept, ovf, zero, taken_n, zcmp;
   assign in_ready = state == IDLE || (state == DONE && out_ready);
   assign accept = in_valid && in_ready;
   assign ext = in_imm_zext ? {16'h0, in_imm} : {{16{in_imm[15]}}, in_imm};
   assign zcmp = in_op >= 5'h0D && in_op <= 5'h10;
   assign b_n = zcmp ? '0 : in_op == 5'h0A ? {in_imm, 16'h0} : (in_use_imm && in_op <= 5'h09) ? ext : in_rt;
   always_comb begin
      case (in_op)
         5'h00, 5'h01: func_n = 6'b000010;
         5'h02, 5'h03, 5'h08, 5'h09, 5'h0D, 5'h0E, 5'h0F, 5'h10: func_n = 6'b000100;
         5'h04: func_n = 6'b001000;
         5'h05: func_n = 6'b010000;
         5'h06: func_n = 6'b100000;
         5'h07: func_n = 6'b010001;
         5'h0A: func_n = 6'b010010;
         5'h0B: func_n = 6'b000110;
         5'h0C: func_n = 6'b100001;
         default: func_n = 6'b001010;
      endcase
   end
   // overflow is derived from operand/result signs; the ALU carry-out is not a signed flag
   assign bp = alu_func == 6'b000100 ? ~alu_b : alu_b;
   assign ovf = (alu_a[31] == bp[31]) && (alu_o[31] != alu_a[31]);
   assign zero = alu_o == '0;
   assign res_n = cur_op >= 5'h0B ? '0 : cur_op == 5'h08 ? {31'b0, alu_o[31] ^ ovf} :
                  cur_op == 5'h09 ? {31'b0, ~alu_err} : alu_o;
   assign taken_n = (cur_op == 5'h0B || cur_op == 5'h0C) ? alu_sgn :
                    cur_op == 5'h0D ? alu_o[31] :
                    cur_op == 5'h0E ? !alu_o[31] :
                    cur_op == 5'h0F ? alu_o[31] | zero :
                    cur_op == 5'h10 ? !alu_o[31] && !zero : 1'b0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         cur_op <= '0;
         alu_a <= '0;
         alu_b <= '0;
         alu_func <= '0;
         out_valid <= 1'b0;
         out_result <= '0;
         out_taken <= 1'b0;
         out_ovf <= 1'b0;
         out_carry <= 1'b0;
         out_illegal <= 1'b0;
      end else if (accept) begin
         alu_a <= in_rs;
         alu_b <= b_n;
         alu_func <= func_n;
         cur_op <= in_op;
         cnt <= CW'(SETTLE_CYCLES - 1);
         out_valid <= 1'b0;
         state <= EXEC;
      end else begin
         case (state)
            EXEC: begin
               if (cnt == '0) begin
                  out_result <= res_n;
                  out_taken <= taken_n;
                  out_ovf <= TRAP_OVF && ovf && (cur_op == 5'h00 || cur_op == 5'h02);
                  out_carry <= alu_err;
                  out_illegal <= cur_op > 5'h10;
                  out_valid <= 1'b1;
                  state <= DONE;
               end else cnt <= cnt - 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
